// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - shared RCC types and default constants
package rcc_pkg;

    typedef enum logic [1:0] {
        LSI_OFF     = 2'b00,
        LSI_STARTUP = 2'b01,
        LSI_RDY     = 2'b10,
        LSI_STOP    = 2'b11
    } lsi_state_e;

    localparam int RCC_LSI_STARTUP_CYCLES = 64;
    localparam int RCC_LSI_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rcc_sync_bit.sv
// rtl/rcc_sync_bit.sv - multi-flop synchroniser for one asynchronous bit
module rcc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/rcc_lsi_ctrl.sv
// rtl/rcc_lsi_ctrl.sv - LSI oscillator enable, ready qualification and clock gating
module rcc_lsi_ctrl
    import rcc_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STARTUP_CYCLES = RCC_LSI_STARTUP_CYCLES,
    parameter int TIMEOUT_CYCLES = RCC_LSI_TIMEOUT_CYCLES,
    parameter int CNT_W          = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lsion,
    input  logic iwdg1_lsi_req,
    input  logic iwdg2_lsi_req,
    input  logic lsirdyie,
    input  logic lsi_ana_rdy,
    output logic lsi_osc_en,
    output logic lsi_rdy,
    output logic lsi_clk_gate_en,
    output logic lsirdy_irq,
    output logic lsi_lost,
    output logic lsi_fail
);

    localparam logic [CNT_W-1:0] DBC_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsi_state_e       r_state;
    lsi_state_e       w_next;
    logic [CNT_W-1:0] r_dbc_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_req;
    logic             w_ana_s;
    logic             w_clr_cnt;
    logic             w_rdy_hit;
    logic             w_lost;

    assign w_req = lsion | iwdg1_lsi_req | iwdg2_lsi_req;

    rcc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ana_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (lsi_ana_rdy),
        .o_sync  (w_ana_s)
    );

    always_comb begin
        w_next    = r_state;
        w_clr_cnt = 1'b0;
        w_rdy_hit = 1'b0;
        w_lost    = 1'b0;
        case (r_state)
            LSI_OFF: begin
                if (w_req) begin
                    w_next    = LSI_STARTUP;
                    w_clr_cnt = 1'b1;
                end
            end
            LSI_STARTUP: begin
                // Dropping the request wins over a same-cycle ready qualification.
                if (!w_req) begin
                    w_next = LSI_STOP;
                end else if (w_ana_s && (r_dbc_cnt == DBC_LAST)) begin
                    w_next    = LSI_RDY;
                    w_rdy_hit = 1'b1;
                end
            end
            LSI_RDY: begin
                if (!w_req) begin
                    w_next = LSI_STOP;
                end else if (!w_ana_s) begin
                    w_next    = LSI_STARTUP;
                    w_clr_cnt = 1'b1;
                    w_lost    = 1'b1;
                end
            end
            LSI_STOP: begin
                if (!w_ana_s) begin
                    w_next = LSI_OFF;
                end
            end
            default: w_next = LSI_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= LSI_OFF;
            r_dbc_cnt       <= '0;
            r_tmo_cnt       <= '0;
            lsi_osc_en      <= 1'b0;
            lsi_rdy         <= 1'b0;
            lsi_clk_gate_en <= 1'b0;
            lsirdy_irq      <= 1'b0;
            lsi_lost        <= 1'b0;
            lsi_fail        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clr_cnt) begin
                r_dbc_cnt <= '0;
                r_tmo_cnt <= '0;
            end else if (r_state == LSI_STARTUP) begin
                r_dbc_cnt <= w_ana_s ? (r_dbc_cnt + CNT_W'(1)) : '0;
                if (r_tmo_cnt != TMO_LAST) begin
                    r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                end
            end
            // Timeout flag survives RDY->STARTUP retries; only a fresh start clears it.
            if ((r_state == LSI_OFF) && w_req) begin
                lsi_fail <= 1'b0;
            end else if ((r_state == LSI_STARTUP) && (r_tmo_cnt == TMO_LAST)) begin
                lsi_fail <= 1'b1;
            end
            lsi_osc_en      <= (w_next == LSI_STARTUP) || (w_next == LSI_RDY);
            lsi_rdy         <= (w_next == LSI_RDY);
            lsi_clk_gate_en <= (w_next == LSI_RDY);
            lsirdy_irq      <= w_rdy_hit & lsirdyie;
            lsi_lost        <= w_lost;
        end
    end

endmodule

// File: tb/tb_rcc_lsi_ctrl.sv
// tb/tb_rcc_lsi_ctrl.sv - directed self-checking bench for rcc_lsi_ctrl
module tb_rcc_lsi_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lsion = 1'b0;
    logic iwdg1_lsi_req = 1'b0;
    logic iwdg2_lsi_req = 1'b0;
    logic lsirdyie = 1'b0;
    logic lsi_ana_rdy = 1'b0;
    logic lsi_osc_en, lsi_rdy, lsi_clk_gate_en, lsirdy_irq, lsi_lost, lsi_fail;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rcc_lsi_ctrl #(
        .SYNC_STAGES    (2),
        .STARTUP_CYCLES (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsion           (lsion),
        .iwdg1_lsi_req   (iwdg1_lsi_req),
        .iwdg2_lsi_req   (iwdg2_lsi_req),
        .lsirdyie        (lsirdyie),
        .lsi_ana_rdy     (lsi_ana_rdy),
        .lsi_osc_en      (lsi_osc_en),
        .lsi_rdy         (lsi_rdy),
        .lsi_clk_gate_en (lsi_clk_gate_en),
        .lsirdy_irq      (lsirdy_irq),
        .lsi_lost        (lsi_lost),
        .lsi_fail        (lsi_fail)
    );

    // Order: osc_en, rdy, gate_en, irq, lost, fail
    wire [5:0] w_outs = {lsi_osc_en, lsi_rdy, lsi_clk_gate_en, lsirdy_irq, lsi_lost, lsi_fail};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL reset_outs got %b exp %b", w_outs, 6'b000000); end
        rst_n = 1'b1;
        tick(2);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL idle_off got %b exp %b", w_outs, 6'b000000); end
    endtask

    task automatic test_startup();
        lsirdyie = 1'b1;
        lsion = 1'b1;
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL startup_c1 got %b exp %b", w_outs, 6'b100000); end
        tick(4);
        lsi_ana_rdy = 1'b1;
        tick(5);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL startup_c10 got %b exp %b", w_outs, 6'b100000); end
        tick(1);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL startup_c11 got %b exp %b", w_outs, 6'b111100); end
        tick(1);
        checks++; if (w_outs !== 6'b111000) begin errors++; $display("FAIL startup_c12 got %b exp %b", w_outs, 6'b111000); end
    endtask

    task automatic test_lost();
        lsi_ana_rdy = 1'b0;
        tick(2);
        checks++; if (w_outs !== 6'b111000) begin errors++; $display("FAIL lost_pre got %b exp %b", w_outs, 6'b111000); end
        tick(1);
        checks++; if (w_outs !== 6'b100010) begin errors++; $display("FAIL lost_pulse got %b exp %b", w_outs, 6'b100010); end
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL lost_once got %b exp %b", w_outs, 6'b100000); end
        lsi_ana_rdy = 1'b1;
        tick(5);
        checks++; if (lsi_rdy !== 1'b0) begin errors++; $display("FAIL lost_rerdy_early got %b exp %b", lsi_rdy, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL lost_rerdy got %b exp %b", w_outs, 6'b111100); end
    endtask

    task automatic test_stop_iwdg();
        lsion = 1'b0;
        tick(1);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL stop_enter got %b exp %b", w_outs, 6'b000000); end
        iwdg2_lsi_req = 1'b1;
        tick(3);
        checks++; if (lsi_osc_en !== 1'b0) begin errors++; $display("FAIL stop_hold got %b exp %b", lsi_osc_en, 1'b0); end
        lsi_ana_rdy = 1'b0;
        tick(3);
        checks++; if (lsi_osc_en !== 1'b0) begin errors++; $display("FAIL stop_off got %b exp %b", lsi_osc_en, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL iwdg_start got %b exp %b", w_outs, 6'b100000); end
        lsi_ana_rdy = 1'b1;
        tick(5);
        checks++; if (lsi_rdy !== 1'b0) begin errors++; $display("FAIL iwdg_rdy_early got %b exp %b", lsi_rdy, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL iwdg_rdy got %b exp %b", w_outs, 6'b111100); end
        iwdg2_lsi_req = 1'b0;
        tick(1);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL iwdg_drop got %b exp %b", w_outs, 6'b000000); end
        lsi_ana_rdy = 1'b0;
        tick(3);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL iwdg_off got %b exp %b", w_outs, 6'b000000); end
    endtask

    task automatic test_glitch();
        lsion = 1'b1;
        lsi_ana_rdy = 1'b1;
        tick(2);
        lsi_ana_rdy = 1'b0;
        tick(1);
        lsi_ana_rdy = 1'b1;
        tick(3);
        checks++; if (lsi_rdy !== 1'b0) begin errors++; $display("FAIL glitch_no_early got %b exp %b", lsi_rdy, 1'b0); end
        tick(2);
        checks++; if (lsi_rdy !== 1'b0) begin errors++; $display("FAIL glitch_c8 got %b exp %b", lsi_rdy, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL glitch_rdy got %b exp %b", w_outs, 6'b111100); end
    endtask

    task automatic test_timeout();
        lsion = 1'b0;
        lsi_ana_rdy = 1'b0;
        tick(4);
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL tmo_off got %b exp %b", w_outs, 6'b000000); end
        lsion = 1'b1;
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL tmo_start got %b exp %b", w_outs, 6'b100000); end
        tick(15);
        checks++; if (lsi_fail !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp %b", lsi_fail, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b100001) begin errors++; $display("FAIL tmo_set got %b exp %b", w_outs, 6'b100001); end
        tick(5);
        checks++; if (w_outs !== 6'b100001) begin errors++; $display("FAIL tmo_sticky got %b exp %b", w_outs, 6'b100001); end
        lsion = 1'b0;
        tick(1);
        lsion = 1'b1;
        tick(1);
        checks++; if (w_outs !== 6'b000001) begin errors++; $display("FAIL tmo_off_keep got %b exp %b", w_outs, 6'b000001); end
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL tmo_clear got %b exp %b", w_outs, 6'b100000); end
    endtask

    task automatic test_reset_mid();
        lsi_ana_rdy = 1'b1;
        tick(6);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL rst_pre_rdy got %b exp %b", w_outs, 6'b111100); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (w_outs !== 6'b000000) begin errors++; $display("FAIL rst_async got %b exp %b", w_outs, 6'b000000); end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checks++; if (w_outs !== 6'b100000) begin errors++; $display("FAIL rst_restart got %b exp %b", w_outs, 6'b100000); end
        tick(4);
        checks++; if (lsi_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy_early got %b exp %b", lsi_rdy, 1'b0); end
        tick(1);
        checks++; if (w_outs !== 6'b111100) begin errors++; $display("FAIL rst_rdy got %b exp %b", w_outs, 6'b111100); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_lost();
        test_stop_iwdg();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcc_lsi_ctrl.md
Name: rcc_lsi_ctrl

Overview:
Controls the LSI oscillator for the RCC VDD domain. It combines the LSION register bit with the independent-watchdog force requests, enables the analog oscillator, and synchronises the oscillator's raw ready signal. It then qualifies that ready signal with a debounce/startup counter and produces the qualified lsi_rdy that feeds the RCC VDD register block's LSIRDY input. It also gates the LSI clock to consumers and flags startup timeout and loss of the oscillator.

Parameters:
SYNC_STAGES, 2, number of flops in the lsi_ana_rdy synchroniser (minimum 2)
STARTUP_CYCLES, 64, consecutive synchronised-ready cycles required before lsi_rdy asserts (minimum 1)
TIMEOUT_CYCLES, 1024, cycles in STARTUP before lsi_fail is raised
CNT_W, 11, width of the shared startup/timeout counters; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  always-on VDD-domain clock
rst_n  in  1  asynchronous active-low reset (driven from ~pwr_por_rst)
lsion  in  1  LSION register bit (cur_rcc_csr_lsion)
iwdg1_lsi_req  in  1  IWDG1 force-on request
iwdg2_lsi_req  in  1  IWDG2 force-on request
lsirdyie  in  1  LSI ready interrupt enable
lsi_ana_rdy  in  1  raw ready from the analog oscillator; asynchronous to clk
lsi_osc_en  out  1  enable to the analog LSI oscillator
lsi_rdy  out  1  qualified ready; drives the lsi_rdy input of the RCC VDD register block
lsi_clk_gate_en  out  1  enable for the LSI clock gate to consumers
lsirdy_irq  out  1  one-cycle pulse when ready is reached
lsi_lost  out  1  one-cycle pulse when the oscillator drops while in RDY
lsi_fail  out  1  sticky startup-timeout flag

Behaviour:
- Reset: all outputs 0, FSM in OFF, counters 0, synchroniser flops 0.
- lsi_req = lsion | iwdg1_lsi_req | iwdg2_lsi_req.
- ana_s is lsi_ana_rdy after SYNC_STAGES flops.
- All outputs are registered and decoded from the FSM state.
- FSM states:
  - OFF: lsi_osc_en=0, lsi_rdy=0, lsi_clk_gate_en=0. If lsi_req=1: go to STARTUP, clear both counters, clear lsi_fail.
  - STARTUP: lsi_osc_en=1.
    - The debounce counter increments on each cycle with ana_s=1 and clears on any cycle with ana_s=0.
    - The timeout counter increments every cycle and saturates.
    - When ana_s=1 and the debounce count equals STARTUP_CYCLES-1: go to RDY. lsi_rdy is therefore high exactly STARTUP_CYCLES cycles after the first ana_s=1 cycle of an unbroken run.
    - When the timeout count equals TIMEOUT_CYCLES-1: set lsi_fail and stay in STARTUP. lsi_fail stays set until the next OFF->STARTUP entry or reset.
    - If lsi_req=0: go to STOP. This takes priority over the ready transition in the same cycle.
  - RDY: lsi_osc_en=1, lsi_rdy=1, lsi_clk_gate_en=1.
    - If lsi_req=0: go to STOP.
    - Otherwise, if ana_s=0: go to STARTUP, clear both counters, pulse lsi_lost for 1 cycle.
  - STOP: lsi_osc_en=0, lsi_rdy=0, lsi_clk_gate_en=0. Stay until ana_s=0, then go to OFF.
    - A lsi_req reassertion during STOP is held off until OFF is reached; it then enters STARTUP on the next cycle.
    - There is no shortcut from STOP back to RDY.
- lsirdy_irq: 1-cycle pulse on the cycle lsi_rdy first reads 1 after STARTUP->RDY, only when lsirdyie=1 in the transition cycle. It does not fire on reset.
- lsi_rdy and lsi_clk_gate_en fall in the same cycle as the transition out of RDY. The gate never stays enabled while lsi_rdy=0.
- lsi_req toggling 1->0->1 inside STARTUP: the FSM passes through STOP/OFF and restarts both counters.
- Reset asserted mid-operation: immediate return to OFF with all outputs 0, including lsi_osc_en.

Decomposition:
- Shared package rcc_pkg:
  - lsi FSM state enum, encoded OFF=2'b00, STARTUP=2'b01, RDY=2'b10, STOP=2'b11
  - default constants RCC_LSI_STARTUP_CYCLES and RCC_LSI_TIMEOUT_CYCLES
- One sub-module rcc_sync_bit: parameterised SYNC_STAGES flop chain, asynchronous active-low reset, reset value 0. It is reused for the other asynchronous analog ready inputs in the RCC.

Test Plan:
1. STARTUP_CYCLES=4, SYNC_STAGES=2. Set lsion=1 at cycle 0 and raise lsi_ana_rdy at cycle 5 -> lsi_osc_en=1 from cycle 1; lsi_rdy=1 from cycle 11 (ana_s high at cycle 7, plus 4); lsirdy_irq high only at cycle 11 with lsirdyie=1.
2. lsi_ana_rdy glitches low for 1 cycle after 2 ready cycles in STARTUP -> debounce counter restarts; lsi_rdy is delayed by the full 4 cycles after ana_s returns high.
3. In RDY, drop lsi_ana_rdy -> lsi_lost pulses once, lsi_rdy and lsi_clk_gate_en fall in the same cycle, FSM returns to STARTUP; raising ana again reaches RDY after 4 cycles.
4. lsion=0 but iwdg2_lsi_req=1 -> LSI starts and reaches RDY. Drop iwdg2_lsi_req -> STOP with lsi_osc_en=0; OFF reached only after ana_s=0.
5. TIMEOUT_CYCLES=16 with lsi_ana_rdy held 0 -> lsi_fail=1 at the 16th STARTUP cycle and sticky. Cycle lsi_req off and on -> lsi_fail clears on the STARTUP entry.
6. Assert rst_n=0 while in RDY -> all outputs 0 asynchronously. After release with lsion=1, a full restart occurs.
